spi_xip_ctrl: RTL and testbench



---
 rtl/spi_xip_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spi_xip_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xip_ctrl.sv
// spi_xip_ctrl: shares the SPI master's Wishbone slave port between CPU register accesses and XIP flash reads.
module spi_xip_ctrl #(
  parameter logic [31:0] CLK_DIV    = 32'h10,
  parameter logic [7:0]  SS_MASK    = 8'h01,
  parameter logic [7:0]  RD_CMD     = 8'h03,
  parameter logic [15:0] POLL_LIMIT = 16'd4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        xip_req_valid,
  output logic        xip_req_ready,
  input  logic [23:0] xip_req_addr,
  output logic        xip_rsp_valid,
  output logic [31:0] xip_rsp_data,
  output logic        xip_rsp_err,
  input  logic        reg_req_valid,
  output logic        reg_req_ready,
  input  logic [4:0]  reg_req_addr,
  input  logic        reg_req_we,
  input  logic [31:0] reg_req_wdata,
  input  logic [3:0]  reg_req_sel,
  output logic        reg_rsp_valid,
  output logic [31:0] reg_rsp_rdata,
  output logic        reg_rsp_err,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        xip_busy
);
  typedef enum logic [3:0] {IDLE, R_ACC, R_RSP, X_TX1, X_DIV, X_SS, X_GO, X_POLL, X_CLRSS, X_RX0, X_RSP} state_t;
  state_t state_q, state_d;
  logic        last_q, last_d, err_q, err_d, stb_q, stb_d, we_q, we_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  adr_q, adr_d, radr_q, radr_d;
  logic [31:0] dat_q, dat_d, rdat_q, rdat_d;
  logic [3:0]  sel_q, sel_d, rsel_q, rsel_d;
  logic        rwe_q, rwe_d;
  logic [23:0] xaddr_q, xaddr_d;
  logic        xrdy_q, xrdy_d, rrdy_q, rrdy_d, busy_q, busy_d;
  logic        xval_q, xval_d, xerr_q, xerr_d, rval_q, rval_d, rerr_q, rerr_d;
  logic [31:0] xdat_q, xdat_d, rrd_q, rrd_d;
  logic        a, e, done, gx, gr, acc;
  // ack together with err counts as err
  assign e    = stb_q & wb_err_i;
  assign a    = stb_q & wb_ack_i & ~wb_err_i;
  assign done = a | e;
  assign gx   = xip_req_valid & (~reg_req_valid | ~last_q);
  assign gr   = reg_req_valid & ~gx;
  assign acc  = state_q inside {R_ACC, X_TX1, X_DIV, X_SS, X_GO, X_POLL, X_CLRSS, X_RX0};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      radr_q  <= '0;
      rdat_q  <= '0;
      rsel_q  <= '0;
      rwe_q   <= 1'b0;
      xaddr_q <= '0;
      xrdy_q  <= 1'b0;
      rrdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      xval_q  <= 1'b0;
      xerr_q  <= 1'b0;
      xdat_q  <= '0;
      rval_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rrd_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      radr_q  <= radr_d;
      rdat_q  <= rdat_d;
      rsel_q  <= rsel_d;
      rwe_q   <= rwe_d;
      xaddr_q <= xaddr_d;
      xrdy_q  <= xrdy_d;
      rrdy_q  <= rrdy_d;
      busy_q  <= busy_d;
      xval_q  <= xval_d;
      xerr_q  <= xerr_d;
      xdat_q  <= xdat_d;
      rval_q  <= rval_d;
      rerr_q  <= rerr_d;
      rrd_q   <= rrd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        cnt_d = '0;
        if (gx) begin
          state_d = X_TX1;
          last_d  = 1'b1;
        end else if (gr) begin
          state_d = R_ACC;
          last_d  = 1'b0;
        end
      end
      R_ACC:        state_d = done ? R_RSP : R_ACC;
      R_RSP, X_RSP: state_d = IDLE;
      X_TX1:        begin err_d = err_q | e; state_d = e ? X_RSP : a ? X_DIV : X_TX1; end
      X_DIV:        begin err_d = err_q | e; state_d = e ? X_RSP : a ? X_SS : X_DIV; end
      X_SS:         begin err_d = err_q | e; state_d = e ? X_CLRSS : a ? X_GO : X_SS; end
      X_GO:         begin err_d = err_q | e; state_d = e ? X_CLRSS : a ? X_POLL : X_GO; end
      X_POLL: begin
        if (e) begin
          err_d   = 1'b1;
          state_d = X_CLRSS;
        end else if (a) begin
          cnt_d = cnt_q + 16'd1;
          if (!wb_dat_i[8]) state_d = X_CLRSS;
          else if (cnt_q + 16'd1 == POLL_LIMIT) begin
            err_d   = 1'b1;
            state_d = X_CLRSS;
          end
        end
      end
      X_CLRSS:      begin err_d = err_q | e; state_d = (e | (a & err_q)) ? X_RSP : a ? X_RX0 : X_CLRSS; end
      X_RX0:        begin err_d = err_q | e; state_d = done ? X_RSP : X_RX0; end
      default:      state_d = IDLE;
    endcase
  end
  always_comb begin
    adr_d = '0;
    dat_d = '0;
    sel_d = '0;
    we_d  = 1'b0;
    case (state_q)
      R_ACC:   begin adr_d = radr_q; dat_d = rdat_q; sel_d = rsel_q; we_d = rwe_q; end
      X_TX1:   begin adr_d = 5'h04; dat_d = {RD_CMD, xaddr_q}; sel_d = 4'hF; we_d = 1'b1; end
      X_DIV:   begin adr_d = 5'h14; dat_d = CLK_DIV; sel_d = 4'hF; we_d = 1'b1; end
      X_SS:    begin adr_d = 5'h18; dat_d = {24'b0, SS_MASK}; sel_d = 4'hF; we_d = 1'b1; end
      X_GO:    begin adr_d = 5'h10; dat_d = 32'h0000_0140; sel_d = 4'hF; we_d = 1'b1; end
      X_POLL:  adr_d = 5'h10;
      X_CLRSS: begin adr_d = 5'h18; sel_d = 4'hF; we_d = 1'b1; end
      default: adr_d = '0;
    endcase
    // strobe waits out the ready cycle so the latched request fields are in place
    stb_d   = stb_q ? ~done : (acc & ~xrdy_q & ~rrdy_q);
    xrdy_d  = (state_q == IDLE) & gx;
    rrdy_d  = (state_q == IDLE) & gr;
    xaddr_d = xrdy_q ? xip_req_addr : xaddr_q;
    radr_d  = rrdy_q ? reg_req_addr : radr_q;
    rdat_d  = rrdy_q ? reg_req_wdata : rdat_q;
    rsel_d  = rrdy_q ? reg_req_sel : rsel_q;
    rwe_d   = rrdy_q ? reg_req_we : rwe_q;
    busy_d  = state_d inside {X_TX1, X_DIV, X_SS, X_GO, X_POLL, X_CLRSS, X_RX0, X_RSP};
    xval_d  = state_d == X_RSP;
    xerr_d  = (state_d == X_RSP) & err_d;
    xdat_d  = (state_d == X_RSP && state_q == X_RX0 && !err_d) ?
              {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]} : 32'h0;
    rval_d  = state_d == R_RSP;
    rerr_d  = (state_d == R_RSP) & e;
    rrd_d   = (state_d == R_RSP) ? wb_dat_i : 32'h0;
  end
  assign xip_req_ready = xrdy_q;
  assign reg_req_ready = rrdy_q;
  assign xip_rsp_valid = xval_q;
  assign xip_rsp_data  = xdat_q;
  assign xip_rsp_err   = xerr_q;
  assign reg_rsp_valid = rval_q;
  assign reg_rsp_rdata = rrd_q;
  assign reg_rsp_err   = rerr_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_stb_o      = stb_q;
  assign wb_cyc_o      = stb_q;
  assign xip_busy      = busy_q;
endmodule

// File: tb/tb_spi_xip_ctrl.sv
// tb_spi_xip_ctrl: directed bench with a small SPI-master Wishbone slave model and a transaction log.
module tb_spi_xip_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic        xip_req_valid = 1'b0, xip_req_ready;
  logic [23:0] xip_req_addr = '0;
  logic        xip_rsp_valid, xip_rsp_err;
  logic [31:0] xip_rsp_data;
  logic        reg_req_valid = 1'b0, reg_req_ready, reg_req_we = 1'b0;
  logic [4:0]  reg_req_addr = '0;
  logic [31:0] reg_req_wdata = '0;
  logic [3:0]  reg_req_sel = '0;
  logic        reg_rsp_valid, reg_rsp_err;
  logic [31:0] reg_rsp_rdata;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i, xip_busy;
  spi_xip_ctrl dut (
    .clock(clock), .reset(reset),
    .xip_req_valid(xip_req_valid), .xip_req_ready(xip_req_ready), .xip_req_addr(xip_req_addr),
    .xip_rsp_valid(xip_rsp_valid), .xip_rsp_data(xip_rsp_data), .xip_rsp_err(xip_rsp_err),
    .reg_req_valid(reg_req_valid), .reg_req_ready(reg_req_ready), .reg_req_addr(reg_req_addr),
    .reg_req_we(reg_req_we), .reg_req_wdata(reg_req_wdata), .reg_req_sel(reg_req_sel),
    .reg_rsp_valid(reg_rsp_valid), .reg_rsp_rdata(reg_rsp_rdata), .reg_rsp_err(reg_rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .xip_busy(xip_busy)
  );
  // slave model: response one cycle after strobe, CTRL busy until the configured poll
  logic ack_q = 1'b0, errr_q = 1'b0, err_arm = 1'b0, bsy_forever = 1'b0, prev_done = 1'b0;
  logic [4:0] err_adr = '0;
  int bsy_polls = 1, polls_seen = 0, n = 0, gap_bad = 0, xrsp_cnt = 0;
  logic [4:0]  la [0:16383];
  logic [31:0] ld [0:16383];
  logic [3:0]  ls [0:16383];
  logic        lw [0:16383];
  logic        le [0:16383];
  logic inj, bsy;
  assign inj      = err_arm && wb_adr_o == err_adr && wb_we_o;
  assign bsy      = bsy_forever || (polls_seen + 1 < bsy_polls);
  assign wb_ack_i = ack_q;
  assign wb_err_i = errr_q;
  assign wb_dat_i = wb_adr_o == 5'h00 ? 32'hAABBCCDD : wb_adr_o == 5'h10 ? {23'b0, bsy, 8'b0} : 32'h12345678;
  always @(posedge clock) begin
    ack_q     <= wb_stb_o && !ack_q && !errr_q && !inj;
    errr_q    <= wb_stb_o && !ack_q && !errr_q && inj;
    prev_done <= wb_stb_o && (wb_ack_i || wb_err_i);
    if (prev_done && wb_stb_o) gap_bad <= gap_bad + 1;
    if (xip_rsp_valid) xrsp_cnt <= xrsp_cnt + 1;
    if (wb_stb_o && (wb_ack_i || wb_err_i)) begin
      la[n] <= wb_adr_o;
      ld[n] <= wb_dat_o;
      ls[n] <= wb_sel_o;
      lw[n] <= wb_we_o;
      le[n] <= wb_err_i;
      n     <= n + 1;
      if (wb_adr_o == 5'h10) polls_seen <= wb_we_o ? 0 : polls_seen + 1;
    end
  end
  int passed = 0, total = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask
  task automatic xip_go(input logic [23:0] a);
    logic got = 1'b0;
    xip_req_addr  = a;
    xip_req_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      got = xip_req_ready;
    end
    chk("xip_ready", {31'b0, got}, 32'd1);
    @(posedge clock);
    #1 xip_req_valid = 1'b0;
  endtask
  task automatic wait_xip(output logic [31:0] d, output logic er);
    logic got = 1'b0;
    d = '0;
    er = 1'b0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clock);
      got = xip_rsp_valid;
      d   = xip_rsp_data;
      er  = xip_rsp_err;
    end
    chk("xip_rsp_seen", {31'b0, got}, 32'd1);
    @(negedge clock);
    chk("xip_rsp_pulse_1cyc", {31'b0, xip_rsp_valid}, 32'd0);
  endtask
  task automatic wait_reg(output logic [31:0] d, output logic er);
    logic got = 1'b0;
    d = '0;
    er = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      got = reg_rsp_valid;
      d   = reg_rsp_rdata;
      er  = reg_rsp_err;
    end
    chk("reg_rsp_seen", {31'b0, got}, 32'd1);
    @(negedge clock);
    chk("reg_rsp_pulse_1cyc", {31'b0, reg_rsp_valid}, 32'd0);
  endtask
  logic [4:0]  ea [9] = '{5'h04, 5'h14, 5'h18, 5'h10, 5'h10, 5'h10, 5'h10, 5'h18, 5'h00};
  logic [31:0] ed [9] = '{32'h03000104, 32'h10, 32'h1, 32'h140, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [3:0]  es [9] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
  logic        ew [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    logic [31:0] d;
    logic er, got, in_xip;
    int base, polls, g, stall_bad, xr;
    int order [3];
    do_reset();
    @(negedge clock);
    chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst_xready", {31'b0, xip_req_ready}, 32'd0);
    chk("rst_rready", {31'b0, reg_req_ready}, 32'd0);
    chk("rst_xrsp", {31'b0, xip_rsp_valid}, 32'd0);
    chk("rst_rrsp", {31'b0, reg_rsp_valid}, 32'd0);
    chk("rst_busy", {31'b0, xip_busy}, 32'd0);
    chk("rst_adr", {27'b0, wb_adr_o}, 32'd0);
    // XIP read, busy cleared on third poll
    bsy_polls = 3;
    base = n;
    xip_go(24'h000104);
    @(negedge clock);
    chk("busy_mid", {31'b0, xip_busy}, 32'd1);
    wait_xip(d, er);
    chk("x1_data", d, 32'hDDCCBBAA);
    chk("x1_err", {31'b0, er}, 32'd0);
    chk("x1_busy_after", {31'b0, xip_busy}, 32'd0);
    chk("x1_count", n - base, 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("x1_adr%0d", i), {27'b0, la[base+i]}, {27'b0, ea[i]});
      chk($sformatf("x1_dat%0d", i), ld[base+i], ed[i]);
      chk($sformatf("x1_sel%0d", i), {28'b0, ls[base+i]}, {28'b0, es[i]});
      chk($sformatf("x1_we%0d", i), {31'b0, lw[base+i]}, {31'b0, ew[i]});
    end
    // CPU register write
    base = n;
    reg_req_addr = 5'h14; reg_req_we = 1'b1; reg_req_wdata = 32'h5; reg_req_sel = 4'h3;
    reg_req_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clock); got = reg_req_ready; end
    chk("r_ready", {31'b0, got}, 32'd1);
    @(posedge clock);
    #1 reg_req_valid = 1'b0;
    wait_reg(d, er);
    chk("r_err", {31'b0, er}, 32'd0);
    chk("r_count", n - base, 32'd1);
    chk("r_adr", {27'b0, la[base]}, 32'h14);
    chk("r_dat", ld[base], 32'h5);
    chk("r_sel", {28'b0, ls[base]}, 32'h3);
    chk("r_we", {31'b0, lw[base]}, 32'd1);
    // arbitration from reset: reg, xip, reg with reg stalled during XIP
    do_reset();
    bsy_polls = 1;
    xip_req_addr = 24'h123456;
    reg_req_addr = 5'h14; reg_req_we = 1'b0; reg_req_sel = 4'hF;
    xip_req_valid = 1'b1;
    reg_req_valid = 1'b1;
    g = 0; stall_bad = 0; in_xip = 1'b0;
    for (int k = 0; k < 300 && g < 3; k++) begin
      @(negedge clock);
      if (xip_rsp_valid) in_xip = 1'b0;
      if (reg_req_ready) begin
        if (in_xip) stall_bad++;
        order[g] = 0; g++;
      end
      if (xip_req_ready && g < 3) begin
        order[g] = 1; g++; in_xip = 1'b1;
      end
    end
    @(posedge clock);
    #1 begin xip_req_valid = 1'b0; reg_req_valid = 1'b0; end
    chk("arb_grants", g, 32'd3);
    chk("arb_g0", order[0], 32'd0);
    chk("arb_g1", order[1], 32'd1);
    chk("arb_g2", order[2], 32'd0);
    chk("arb_stall", stall_bad, 32'd0);
    wait_reg(d, er);
    chk("arb_rdata", d, 32'h12345678);
    // poll timeout
    bsy_forever = 1'b1;
    base = n;
    xip_go(24'h000000);
    wait_xip(d, er);
    bsy_forever = 1'b0;
    polls = 0;
    for (int i = base; i < n; i++) if (la[i] == 5'h10 && !lw[i]) polls++;
    chk("to_polls", polls, 32'd4096);
    chk("to_count", n - base, 32'd4101);
    chk("to_last_adr", {27'b0, la[n-1]}, 32'h18);
    chk("to_last_dat", ld[n-1], 32'h0);
    chk("to_last_we", {31'b0, lw[n-1]}, 32'd1);
    chk("to_err", {31'b0, er}, 32'd1);
    chk("to_data", d, 32'h0);
    // bus error on GO write
    bsy_polls = 3;
    err_adr = 5'h10; err_arm = 1'b1;
    base = n;
    xip_go(24'h000010);
    wait_xip(d, er);
    err_arm = 1'b0;
    chk("go_count", n - base, 32'd5);
    chk("go_err_adr", {27'b0, la[base+3]}, 32'h10);
    chk("go_err_flag", {31'b0, le[base+3]}, 32'd1);
    chk("go_next_adr", {27'b0, la[base+4]}, 32'h18);
    chk("go_next_dat", ld[base+4], 32'h0);
    chk("go_rsp_err", {31'b0, er}, 32'd1);
    chk("go_rsp_data", d, 32'h0);
    // bus error on TX1 write: SS never touched
    err_adr = 5'h04; err_arm = 1'b1;
    base = n;
    xip_go(24'h000020);
    wait_xip(d, er);
    err_arm = 1'b0;
    chk("tx_count", n - base, 32'd1);
    chk("tx_rsp_err", {31'b0, er}, 32'd1);
    // reset during a poll strobe
    bsy_forever = 1'b1;
    xip_go(24'h000030);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clock);
      got = wb_stb_o && wb_adr_o == 5'h10 && !wb_we_o;
    end
    chk("rst_poll_seen", {31'b0, got}, 32'd1);
    xr = xrsp_cnt;
    reset = 1'b1;
    @(negedge clock);
    chk("rstp_stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rstp_cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rstp_busy", {31'b0, xip_busy}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    bsy_forever = 1'b0;
    bsy_polls = 1;
    repeat (5) @(negedge clock);
    chk("rstp_no_rsp", xrsp_cnt - xr, 32'd0);
    base = n;
    xip_go(24'hABCDEF);
    wait_xip(d, er);
    chk("rx_count", n - base, 32'd7);
    chk("rx_tx1_adr", {27'b0, la[base]}, 32'h04);
    chk("rx_tx1_dat", ld[base], 32'h03ABCDEF);
    chk("rx_last_adr", {27'b0, la[n-1]}, 32'h00);
    chk("rx_data", d, 32'hDDCCBBAA);
    chk("rx_err", {31'b0, er}, 32'd0);
    chk("idle_gap", gap_bad, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
